chip_prog_receiver: RTL and testbench



---
 rtl/chip_prog_receiver_pkg.sv | 8 +
 rtl/chip_prog_receiver_if.sv | 11 +
 rtl/chip_prog_receiver_serial_in_sync.sv | 29 ++
 rtl/chip_prog_receiver.sv | 93 +++++++++
 tb/tb_chip_prog_receiver.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/chip_prog_receiver_pkg.sv
// chip_prog_pkg: frame geometry, gain register address and receiver FSM states
package chip_prog_pkg;
    localparam int FRAME_BITS = 5;
    localparam int ADDR_BITS  = 2;
    localparam int DATA_BITS  = 3;
    localparam logic [ADDR_BITS-1:0] GAIN_ADDR = '0;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
endpackage

// File: rtl/chip_prog_receiver_if.sv
// chip_prog_receiver_if: FPGA programming link pins and amplifier gain outputs
interface chip_prog_receiver_if;
    import chip_prog_pkg::*;
    logic                 i_sclk;
    logic                 i_sdin;
    logic [DATA_BITS-1:0] o_gainA1;
    logic                 o_ready;
    logic                 o_frame_err;
    modport master (output i_sclk, i_sdin, input o_gainA1, o_ready, o_frame_err);
    modport slave  (input i_sclk, i_sdin, output o_gainA1, o_ready, o_frame_err);
endinterface

// File: rtl/chip_prog_receiver_serial_in_sync.sv
// serial_in_sync: brings sclk/sdin into the main clock domain and flags sclk rising edges
module serial_in_sync (
    input  logic i_mainclk,
    input  logic i_resetbAll,
    input  logic i_sclk,
    input  logic i_sdin,
    output logic o_rise,
    output logic o_bit
);
    logic r_sclk_m, r_sclk_s, r_sclk_h, r_sdin_m, r_sdin_s;
    // sclk flops reset high so an idle-high sclk never looks like an edge after reset
    always_ff @(posedge i_mainclk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            r_sclk_m <= 1'b1;
            r_sclk_s <= 1'b1;
            r_sclk_h <= 1'b1;
            r_sdin_m <= 1'b0;
            r_sdin_s <= 1'b0;
        end else begin
            r_sclk_m <= i_sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_h <= r_sclk_s;
            r_sdin_m <= i_sdin;
            r_sdin_s <= r_sdin_m;
        end
    end
    assign o_rise = r_sclk_s & ~r_sclk_h;
    assign o_bit  = r_sdin_s;
endmodule

// File: rtl/chip_prog_receiver.sv
// chip_prog_receiver: shifts in one MSB-first address/data frame and programs the gain register
module chip_prog_receiver
    import chip_prog_pkg::*;
#(
    parameter logic [DATA_BITS-1:0] GAIN_RST = '0,
    parameter int                   TIMEOUT  = 255
) (
    input logic           i_mainclk,
    input logic           i_resetbAll,
    chip_prog_receiver_if.slave prog
);
    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic w_rise, w_bit;
    state_t r_state, w_state;
    logic [FRAME_BITS-1:0] r_shift, w_shift;
    logic [BC_W-1:0] r_bitcnt, w_bitcnt, w_bitcnt_inc;
    logic [TO_W-1:0] r_tocnt, w_tocnt;
    logic [DATA_BITS-1:0] r_gain, w_gain;
    logic r_ready, w_ready, r_err, w_err;
    serial_in_sync u_sync (
        .i_mainclk  (i_mainclk),
        .i_resetbAll(i_resetbAll),
        .i_sclk     (prog.i_sclk),
        .i_sdin     (prog.i_sdin),
        .o_rise     (w_rise),
        .o_bit      (w_bit)
    );
    always_ff @(posedge i_mainclk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
            r_gain   <= GAIN_RST;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_bitcnt <= w_bitcnt;
            r_tocnt  <= w_tocnt;
            r_gain   <= w_gain;
            r_ready  <= w_ready;
            r_err    <= w_err;
        end
    end
    assign w_bitcnt_inc = r_bitcnt + BC_W'(1);
    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_bitcnt = r_bitcnt;
        w_tocnt  = r_tocnt;
        w_gain   = r_gain;
        w_ready  = r_ready;
        w_err    = r_err;
        unique case (r_state)
            IDLE: if (w_rise) begin
                w_shift  = {{(FRAME_BITS-1){1'b0}}, w_bit};
                w_bitcnt = BC_W'(1);
                w_tocnt  = '0;
                w_state  = SHIFT;
            end
            SHIFT: if (w_rise) begin
                w_shift  = {r_shift[FRAME_BITS-2:0], w_bit};
                w_bitcnt = w_bitcnt_inc;
                w_tocnt  = '0;
                w_state  = (w_bitcnt_inc == BC_W'(FRAME_BITS)) ? LATCH : SHIFT;
            end else if (r_tocnt == TO_W'(TIMEOUT)) begin
                w_err    = 1'b1;
                w_shift  = '0;
                w_bitcnt = '0;
                w_tocnt  = '0;
                w_state  = IDLE;
            end else begin
                w_tocnt  = r_tocnt + TO_W'(1);
            end
            LATCH: if (r_shift[FRAME_BITS-1 -: ADDR_BITS] == GAIN_ADDR) begin
                w_gain   = r_shift[DATA_BITS-1:0];
                w_ready  = 1'b1;
                w_state  = DONE;
            end else begin
                w_err    = 1'b1;
                w_bitcnt = '0;
                w_state  = IDLE;
            end
            DONE: w_state = DONE;
        endcase
    end
    assign prog.o_gainA1    = r_gain;
    assign prog.o_ready     = r_ready;
    assign prog.o_frame_err = r_err;
endmodule

// File: tb/tb_chip_prog_receiver.sv
// tb_chip_prog_receiver: directed frames exercising programming, mismatch, timeout, reset and fast sclk
module tb_chip_prog_receiver;
    import chip_prog_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nchk = 0;
    int nerr = 0;
    chip_prog_receiver_if prog ();
    chip_prog_receiver dut (.i_mainclk(clk), .i_resetbAll(rst_n), .prog(prog));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int half);
        @(negedge clk);
        prog.i_sclk = 1'b0;
        prog.i_sdin = b;
        repeat (half) @(negedge clk);
        prog.i_sclk = 1'b1;
        repeat (half - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [4:0] f, input int half);
        for (int i = 4; i >= 0; i--) send_bit(f[i], half);
        repeat (8) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        prog.i_sclk = 1'b1;
        prog.i_sdin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int rises;
        prog.i_sclk = 1'b1;
        prog.i_sdin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gain", prog.o_gainA1, 0);
        check("rst_ready", prog.o_ready, 0);
        check("rst_err", prog.o_frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", dut.r_state, IDLE);

        for (int i = 4; i >= 1; i--) send_bit(i == 2, 16);
        @(negedge clk);
        prog.i_sclk = 1'b0;
        prog.i_sdin = 1'b0;
        repeat (16) @(negedge clk);
        prog.i_sclk = 1'b1;
        n = 0;
        while (!dut.u_sync.o_rise && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("nom_rise_seen", 32'(n < 10), 1);
        check("nom_ready_rise", prog.o_ready, 0);
        @(negedge clk);
        check("nom_ready_latch", prog.o_ready, 0);
        @(negedge clk);
        check("nom_ready", prog.o_ready, 1);
        check("nom_gain", prog.o_gainA1, 4);
        check("nom_err", prog.o_frame_err, 0);

        apply_reset();
        send_frame(5'b00111, 16);
        check("g7_gain", prog.o_gainA1, 7);
        check("g7_ready", prog.o_ready, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 16);
        repeat (8) @(negedge clk);
        check("g7_hold_gain", prog.o_gainA1, 7);
        check("g7_hold_ready", prog.o_ready, 1);

        apply_reset();
        send_frame(5'b01101, 16);
        check("mm_err", prog.o_frame_err, 1);
        check("mm_ready", prog.o_ready, 0);
        check("mm_gain", prog.o_gainA1, 0);
        send_frame(5'b00011, 16);
        check("mm2_gain", prog.o_gainA1, 3);
        check("mm2_ready", prog.o_ready, 1);
        check("mm2_err", prog.o_frame_err, 1);

        apply_reset();
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        check("to_err_before", prog.o_frame_err, 0);
        repeat (300) @(negedge clk);
        check("to_err", prog.o_frame_err, 1);
        check("to_state", dut.r_state, IDLE);
        check("to_bitcnt", 32'(dut.r_bitcnt), 0);
        check("to_ready", prog.o_ready, 0);
        send_frame(5'b00101, 16);
        check("to2_gain", prog.o_gainA1, 5);
        check("to2_ready", prog.o_ready, 1);

        apply_reset();
        send_frame(5'b00100, 16);
        check("mid_pre_ready", prog.o_ready, 1);
        apply_reset();
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        check("mid_bitcnt_pre", 32'(dut.r_bitcnt), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_bitcnt", 32'(dut.r_bitcnt), 0);
        check("mid_shift", 32'(dut.r_shift), 0);
        check("mid_state", dut.r_state, IDLE);
        check("mid_gain", prog.o_gainA1, 0);
        check("mid_ready", prog.o_ready, 0);
        check("mid_err", prog.o_frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rises += int'(dut.u_sync.o_rise);
        end
        check("mid_no_rise", rises, 0);
        send_frame(5'b00110, 16);
        check("mid2_gain", prog.o_gainA1, 6);
        check("mid2_ready", prog.o_ready, 1);

        apply_reset();
        send_frame(5'b00001, 3);
        check("min_gain", prog.o_gainA1, 1);
        check("min_ready", prog.o_ready, 1);
        check("min_err", prog.o_frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
